// File: rtl/polytris_pkg.sv
// Shared definitions for the polytris piece-control blocks: FSM state
// encoding and the default timing parameters.
package polytris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FALL = 3'd1,
        ST_REQ  = 3'd2,
        ST_REST = 3'd3,
        ST_LOCK = 3'd4
    } state_e;

    // Plain constants of the same encoding for logic-typed state registers.
    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_FALL = ST_FALL;
    localparam logic [2:0] S_REQ  = ST_REQ;
    localparam logic [2:0] S_REST = ST_REST;
    localparam logic [2:0] S_LOCK = ST_LOCK;

    localparam int DEF_LOCK_DELAY      = 24000000;
    localparam int DEF_LOCK_RESETS_MAX = 15;

endpackage

// File: rtl/lock_timer.sv
// Clearable up-counter that stops at LOCK_DELAY-1 and flags the terminal
// count; measures how long a resting piece has been on the stack.
module lock_timer
    import polytris_pkg::*;
#(
    parameter int LOCK_DELAY = DEF_LOCK_DELAY
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int              CW   = $clog2(LOCK_DELAY);
    localparam logic [CW-1:0]   TERM = CW'(LOCK_DELAY - 1);

    logic [CW-1:0] r_count;

    // Holding at the terminal value keeps the count from wrapping if the
    // controller lingers in REST for a retry on the last cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TERM)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_terminal = (r_count == TERM);

endmodule

// File: rtl/gravity_step_ctrl.sv
// Turns gravity ticks and hard drops into board move-down requests, runs the
// lock delay for a resting piece and emits a single lock pulse.
// Optional feature macro: LOCK_RESET_EN (piece_moved restarts the lock delay).
module gravity_step_ctrl
    import polytris_pkg::*;
#(
    parameter int LOCK_DELAY      = DEF_LOCK_DELAY,
    parameter int ROW_W           = 5,
    parameter int LOCK_RESETS_MAX = DEF_LOCK_RESETS_MAX
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             piece_clk,
    input  logic             spawn,
    input  logic             hard_drop,
    input  logic             piece_moved,
    output logic             move_req,
    input  logic             move_ack,
    input  logic             move_blocked,
    output logic             lock,
    output logic             active,
    output logic [ROW_W-1:0] drop_rows
);

    logic [2:0]       r_state;
    logic             r_hd;
    logic [ROW_W-1:0] r_dropRows;
    logic             r_moveReq;
    logic             r_lock;
    logic             r_active;

    logic [2:0] w_nextState;
    logic       w_setHd;
    logic       w_timerClear;
    logic       w_incRows;
    logic       w_terminal;
    logic       w_lockReset;

`ifdef LOCK_RESET_EN
    localparam int RCW = $clog2(LOCK_RESETS_MAX + 2);

    logic [RCW-1:0] r_resetCnt;

    // A lateral move only buys time when nothing else is moving the piece down.
    assign w_lockReset = (r_state == S_REST) && piece_moved && !spawn &&
                         !piece_clk && !hard_drop &&
                         (r_resetCnt != RCW'(LOCK_RESETS_MAX));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_resetCnt <= '0;
        end else if (spawn) begin
            r_resetCnt <= '0;
        end else if (w_lockReset) begin
            r_resetCnt <= r_resetCnt + RCW'(1);
        end
    end
`else
    logic w_unusedMoved;

    assign w_lockReset   = 1'b0;
    assign w_unusedMoved = piece_moved | (LOCK_RESETS_MAX == 0);
`endif

    lock_timer #(
        .LOCK_DELAY (LOCK_DELAY)
    ) u_lockTimer (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_clear    (w_timerClear),
        .i_enable   (r_state == S_REST),
        .o_terminal (w_terminal)
    );

    // Spawn overrides everything, including a lock about to fire. A set hd
    // flag sends FALL straight back to REQ, which leaves one idle cycle
    // between an ack and the next request during a hard drop.
    always_comb begin
        w_nextState  = r_state;
        w_setHd      = 1'b0;
        w_timerClear = 1'b0;
        w_incRows    = 1'b0;
        if (spawn) begin
            w_nextState  = S_FALL;
            w_timerClear = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timerClear = 1'b1;
                end
                S_FALL: begin
                    if (hard_drop) begin
                        w_setHd     = 1'b1;
                        w_nextState = S_REQ;
                    end else if (piece_clk || r_hd) begin
                        w_nextState = S_REQ;
                    end
                end
                S_REQ: begin
                    if (hard_drop) begin
                        w_setHd = 1'b1;
                    end
                    if (move_ack) begin
                        if (!move_blocked) begin
                            w_incRows   = 1'b1;
                            w_nextState = S_FALL;
                        end else if (r_hd || hard_drop) begin
                            w_nextState = S_LOCK;
                        end else begin
                            w_nextState  = S_REST;
                            w_timerClear = 1'b1;
                        end
                    end
                end
                S_REST: begin
                    if (piece_clk) begin
                        w_nextState = S_REQ;
                    end else if (hard_drop) begin
                        w_setHd     = 1'b1;
                        w_nextState = S_REQ;
                    end else if (w_lockReset) begin
                        w_timerClear = 1'b1;
                    end else if (w_terminal) begin
                        w_nextState = S_LOCK;
                    end
                end
                S_LOCK: begin
                    w_nextState = S_IDLE;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they change together
    // with the state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_hd       <= 1'b0;
            r_dropRows <= '0;
            r_moveReq  <= 1'b0;
            r_lock     <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_moveReq <= (w_nextState == S_REQ);
            r_lock    <= (w_nextState == S_LOCK);
            r_active  <= (w_nextState != S_IDLE);
            if (spawn || (r_state == S_IDLE)) begin
                r_hd       <= 1'b0;
                r_dropRows <= '0;
            end else begin
                if (w_setHd) begin
                    r_hd <= 1'b1;
                end
                if (w_incRows && (r_dropRows != '1)) begin
                    r_dropRows <= r_dropRows + ROW_W'(1);
                end
            end
        end
    end

    assign move_req  = r_moveReq;
    assign lock      = r_lock;
    assign active    = r_active;
    assign drop_rows = r_dropRows;

endmodule

// File: tb/tb_gravity_step_ctrl.sv
// Directed bench for gravity_step_ctrl with LOCK_DELAY=8; the lock-reset
// section runs only when LOCK_RESET_EN is defined.
module tb_gravity_step_ctrl;

    localparam int LOCK_DELAY      = 8;
    localparam int ROW_W           = 5;
    localparam int LOCK_RESETS_MAX = 2;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             piece_clk;
    logic             spawn;
    logic             hard_drop;
    logic             piece_moved;
    logic             move_req;
    logic             move_ack;
    logic             move_blocked;
    logic             lock;
    logic             active;
    logic [ROW_W-1:0] drop_rows;

    int total = 0;
    int bad   = 0;
    int reqCount  = 0;
    int lockCount = 0;
    logic prevReq = 1'b0;
    int markReq;
    int markLock;

    gravity_step_ctrl #(
        .LOCK_DELAY      (LOCK_DELAY),
        .ROW_W           (ROW_W),
        .LOCK_RESETS_MAX (LOCK_RESETS_MAX)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .piece_clk    (piece_clk),
        .spawn        (spawn),
        .hard_drop    (hard_drop),
        .piece_moved  (piece_moved),
        .move_req     (move_req),
        .move_ack     (move_ack),
        .move_blocked (move_blocked),
        .lock         (lock),
        .active       (active),
        .drop_rows    (drop_rows)
    );

    always #5 CLK = ~CLK;

    // Count request rising edges and lock-high cycles, sampled mid-cycle.
    always @(negedge CLK) begin
        if (move_req && !prevReq) reqCount++;
        prevReq = move_req;
        if (lock) lockCount++;
    end

    // Drive one cycle of inputs, let the edge capture them, then idle them.
    task automatic applyStimulus(input logic pc, input logic sp, input logic hd,
                                 input logic pm, input logic ack, input logic blk);
        piece_clk    = pc;
        spawn        = sp;
        hard_drop    = hd;
        piece_moved  = pm;
        move_ack     = ack;
        move_blocked = blk;
        @(posedge CLK);
        #1;
        piece_clk    = 1'b0;
        spawn        = 1'b0;
        hard_drop    = 1'b0;
        piece_moved  = 1'b0;
        move_ack     = 1'b0;
        move_blocked = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        RESET_N      = 1'b0;
        piece_clk    = 1'b0;
        spawn        = 1'b0;
        hard_drop    = 1'b0;
        piece_moved  = 1'b0;
        move_ack     = 1'b0;
        move_blocked = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_req",    32'(move_req),  0);
        checkOutput("rst_lock",   32'(lock),      0);
        checkOutput("rst_active", 32'(active),    0);
        checkOutput("rst_rows",   32'(drop_rows), 0);
        RESET_N = 1'b1;
        idle(1);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("idle_tick_req", 32'(move_req), 0);
        checkOutput("idle_active",   32'(active),   0);

        $display("[TB] basic fall and lock delay");
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("spawn_active", 32'(active),   1);
        checkOutput("spawn_req",    32'(move_req), 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0);
            checkOutput("tick_req", 32'(move_req), 1);
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("ack_req_low", 32'(move_req), 0);
            checkOutput("ack_rows", 32'(drop_rows), 32'(k));
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("blk_req_low", 32'(move_req), 0);
        checkOutput("blk_rows",    32'(drop_rows), 3);
        markLock = lockCount;
        idle(3);
`ifndef LOCK_RESET_EN
        applyStimulus(0, 0, 0, 1, 0, 0);
`else
        idle(1);
`endif
        idle(3);
        checkOutput("rest7_lock", 32'(lock), 0);
        checkOutput("rest7_nolock_yet", 32'(lockCount - markLock), 0);
        idle(1);
        checkOutput("rest8_lock",   32'(lock),      1);
        checkOutput("rest8_active", 32'(active),    1);
        checkOutput("rest8_rows",   32'(drop_rows), 3);
        idle(1);
        checkOutput("post_lock",   32'(lock),   0);
        checkOutput("post_active", 32'(active), 0);
        checkOutput("lock_once",   32'(lockCount - markLock), 1);

        $display("[TB] hard drop, five moves then block");
        applyStimulus(0, 1, 0, 0, 0, 0);
        markReq = reqCount;
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("hd_req", 32'(move_req), 1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            checkOutput("hd_gap", 32'(move_req), 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("hd_rereq", 32'(move_req), 1);
        end
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("hd_lock",  32'(lock),      1);
        checkOutput("hd_rows",  32'(drop_rows), 5);
        checkOutput("hd_nreq",  32'(reqCount - markReq), 6);
        idle(1);
        checkOutput("hd_done", 32'(active), 0);

        $display("[TB] drop_rows saturation");
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 33; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0, 0);
        end
        checkOutput("sat_rows", 32'(drop_rows), 31);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("sat_lock", 32'(lock), 1);
        idle(1);

        $display("[TB] retry from rest");
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        markLock = lockCount;
        idle(3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("retry_req", 32'(move_req), 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("retry_rows", 32'(drop_rows), 1);
        idle(10);
        checkOutput("retry_nolock", 32'(lockCount - markLock), 0);
        checkOutput("retry_req_idle", 32'(move_req), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        idle(7);
        checkOutput("restart7_lock", 32'(lock), 0);
        idle(1);
        checkOutput("restart8_lock", 32'(lock), 1);
        idle(1);

        $display("[TB] spawn during rest");
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        markLock = lockCount;
        idle(7);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sp_lock",   32'(lock),      0);
        checkOutput("sp_active", 32'(active),    1);
        checkOutput("sp_rows",   32'(drop_rows), 0);
        checkOutput("sp_req",    32'(move_req),  0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("stray_ack_req",  32'(move_req),  0);
        checkOutput("stray_ack_rows", 32'(drop_rows), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("req_hold", 32'(move_req), 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("req_tick_ack_rows", 32'(drop_rows), 1);
        idle(1);
        checkOutput("tick_not_queued", 32'(move_req), 0);
        idle(3);
        checkOutput("sp_nolock", 32'(lockCount - markLock), 0);

        $display("[TB] async reset mid request");
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_req", 32'(move_req), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_req",    32'(move_req),  0);
        checkOutput("mid_rst_lock",   32'(lock),      0);
        checkOutput("mid_rst_active", 32'(active),    0);
        checkOutput("mid_rst_rows",   32'(drop_rows), 0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        markReq = reqCount;
        applyStimulus(0, 0, 0, 0, 1, 0);
        idle(3);
        checkOutput("after_rst_req",    32'(move_req), 0);
        checkOutput("after_rst_active", 32'(active),   0);
        checkOutput("after_rst_nreq",   32'(reqCount - markReq), 0);

`ifdef LOCK_RESET_EN
        $display("[TB] lock reset limit");
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        markLock = lockCount;
        idle(2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0, 0);
        idle(4);
        checkOutput("lr_e13_lock", 32'(lock), 0);
        checkOutput("lr_e13_none", 32'(lockCount - markLock), 0);
        idle(1);
        checkOutput("lr_e14_lock", 32'(lock), 1);
        idle(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gravity_step_ctrl.md
# gravity_step_ctrl

Consumes the gravity tick produced by the level clock divider and turns it into board move-down requests for the active piece. Handles the request/acknowledge exchange with the board collision logic, runs the lock delay once the piece rests, resolves hard drop, and emits a single lock pulse that commits the piece. Sits between the gravity clock divider and the board/piece state logic.

## Interface
- LOCK_DELAY, 24000000: cycles a resting piece waits before locking (0.5 s at 48 MHz); must be ≥2
- ROW_W, 5: width of drop_rows
- LOCK_RESETS_MAX, 15: maximum lock-delay restarts per piece (used only with LOCK_RESET_EN)
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- piece_clk  in  1  one-cycle gravity tick
- spawn  in  1  one-cycle pulse: a new piece is on the board
- hard_drop  in  1  one-cycle pulse: drop to floor and lock
- piece_moved  in  1  one-cycle pulse: lateral move/rotate succeeded
- move_req  out  1  request board to move the piece down one row
- move_ack  in  1  board response valid
- move_blocked  in  1  valid with move_ack; 1 = move refused (collision)
- lock  out  1  one-cycle pulse: commit piece
- active  out  1  a piece is under control
- drop_rows  out  ROW_W  rows fallen since spawn, saturating at all-ones

## Operation
- States: IDLE, FALL, REQ, REST, LOCK.
- IDLE: wait for spawn → FALL; clear drop_rows, lock counter, reset count, hard-drop flag.
- FALL: piece_clk → REQ. hard_drop → set hd flag, → REQ.
- REQ: move_req high, held until move_ack. On ack: not blocked → drop_rows+1 (saturating); if hd flag → REQ again, else → FALL. Blocked → LOCK if hd flag, else REST with lock counter cleared.
- REST: counter increments every cycle. piece_clk → REQ (retry; counter retained). hard_drop → set hd flag, → REQ. Counter reaches LOCK_DELAY-1 → LOCK.
- LOCK: lock high for one cycle → IDLE.
- spawn in any non-IDLE state: abandon current piece (no lock pulse), reinitialise as from IDLE, → FALL.
- piece_clk outside FALL/REST is dropped, never queued. hard_drop in REQ sets hd flag; applies at ack. hard_drop in IDLE/LOCK ignored.
- move_ack while move_req low is ignored; move_blocked ignored without move_ack.
- active = state ≠ IDLE.

## Timing
- Reset (RESET_N low, async): state IDLE, move_req 0, lock 0, active 0, drop_rows 0, all counters 0. Outputs registered.
- spawn at cycle n → active=1 at n+1.
- Tick in FALL at cycle n → move_req=1 at n+1. Ack sampled at rising edge with move_req=1; move_req=0 the following cycle. Ack may arrive in the first move_req cycle.
- Successful ack at n → drop_rows updated at n+1.
- Blocked ack at n (no hd) → REST at n+1; lock pulse at n+1+LOCK_DELAY if no retry succeeds.
- Hard drop: back-to-back requests, one idle cycle between ack and next move_req; blocked ack at n → lock at n+1.
- spawn and lock-in-progress on same cycle: spawn wins, no lock pulse.

## Configuration
- LOCK_RESET_EN defined: piece_moved in REST clears lock counter, at most LOCK_RESETS_MAX times per piece (count cleared on spawn); further pulses ignored. piece_moved in REST with a same-cycle piece_clk: the tick takes priority.
- Not defined: piece_moved port present but ignored; lock fires exactly LOCK_DELAY cycles after entering REST unless a retry succeeds.

## Structure
- Shared package polytris_pkg: state enum type, default LOCK_DELAY, LOCK_RESETS_MAX.
- Sub-module lock_timer: clearable counter with terminal-count output, width $clog2(LOCK_DELAY).

## Test plan
- Reset mid-REQ with move_req=1 → move_req, lock, active, drop_rows all 0 immediately; no request after release.
- LOCK_DELAY=8: spawn, 3 ticks acked unblocked, 4th blocked → drop_rows=3, lock pulse 8 cycles after REST entry, active=0 next cycle.
- Hard drop after spawn, board passes 5 moves then blocks → 6 requests, drop_rows=5, lock 1 cycle after blocked ack.
- In REST, tick retry acked unblocked → back to FALL, no lock; next blocked ack restarts counter from 0.
- spawn asserted during REST → no lock pulse, drop_rows=0, FALL; ticks in REQ and stray move_ack ignored.
- LOCK_RESET_EN, LOCK_DELAY=8, LOCK_RESETS_MAX=2: three piece_moved pulses in REST → lock delayed by first two only.
